// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digits and Overflow are registered and only change when a conversion completes.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = 9999
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Binary,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic [3:0]       BCD3,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD0
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAXVAL);

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [15:0]      scratch_q;
    logic [CW-1:0]    cnt_q;
    logic             ovf_flag_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic [15:0]      bcd_q;

    logic [15:0]      scratch_adj_d;
    logic             over_d;

    // When MAXVAL is not representable in WIDTH bits, over_d is never set.
    assign over_d = 32'(Binary) > 32'(MAXVAL);

    always_comb begin
        scratch_adj_d = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= Start;
                    if (Start) begin
                        bin_q      <= over_d ? MAX_W : Binary;
                        ovf_flag_q <= over_d;
                        scratch_q  <= '0;
                        cnt_q      <= CW'(WIDTH);
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch_q <= {scratch_adj_d[14:0], bin_q[WIDTH-1]};
                    bin_q     <= {bin_q[WIDTH-2:0], 1'b0};
                    cnt_q     <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Busy stays high through the Done cycle; IDLE drops it next edge.
                    bcd_q   <= scratch_q;
                    ovf_q   <= ovf_flag_q;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Overflow = ovf_q;
    assign BCD3     = bcd_q[15:12];
    assign BCD2     = bcd_q[11:8];
    assign BCD1     = bcd_q[7:4];
    assign BCD0     = bcd_q[3:0];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected digits,
// a negedge monitor pops and compares on every Done pulse.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [13:0] Binary;
    logic        Busy, Done, Overflow;
    logic [3:0]  BCD3, BCD2, BCD1, BCD0;

    exp_t        sb_q[$];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [15:0] last_bcd = '0;
    logic        last_ovf = 1'b0;
    exp_t        popped;

    bin_to_bcd_seq #(.WIDTH(14), .MAXVAL(9999)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Binary(Binary),
        .Busy(Busy), .Done(Done), .Overflow(Overflow),
        .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] dec(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Called at a negedge; returns at the negedge after the Done cycle.
    task automatic convert(input logic [13:0] bin, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input bit extra_start);
        int n;
        sb_q.push_back('{exp_bcd, exp_ovf});
        Start  = 1'b1;
        Binary = bin;
        @(negedge Clk);
        Start = 1'b0;
        n = 1;
        chk("busy_after_start", Busy, 1);
        while (!Done && n < 40) begin
            @(negedge Clk);
            n++;
            Start = extra_start && (n == 5);
            if (extra_start && n == 5) Binary = 14'd1111;
        end
        chk("done_latency", n, 16);
        @(negedge Clk);
        chk("busy_after_done", Busy, 0);
        chk("done_one_cycle", Done, 0);
    endtask

    task automatic expect_no_done(input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge Clk);
            if (Done) seen++;
        end
        chk("no_extra_done", seen, 0);
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            last_bcd = '0;
            last_ovf = 1'b0;
        end else if (Done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                popped = sb_q.pop_front();
                chk("bcd_digits", {BCD3, BCD2, BCD1, BCD0}, popped.bcd);
                chk("overflow", Overflow, popped.ovf);
            end
            chk("digit_range", (BCD3 <= 9) && (BCD2 <= 9) && (BCD1 <= 9) && (BCD0 <= 9), 1);
            last_bcd = {BCD3, BCD2, BCD1, BCD0};
            last_ovf = Overflow;
        end else begin
            chk("hold_digits", {BCD3, BCD2, BCD1, BCD0}, last_bcd);
            chk("hold_ovf", Overflow, last_ovf);
        end
    end

    logic [13:0] bvals [6] = '{14'd0, 14'd9, 14'd10, 14'd999, 14'd1000, 14'd9999};
    logic [15:0] bexp  [6] = '{16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h1000, 16'h9999};

    initial begin
        int n;
        Reset  = 1'b0;
        Start  = 1'b0;
        Binary = '0;
        #23;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_ovf", Overflow, 0);
        chk("reset_bcd", {BCD3, BCD2, BCD1, BCD0}, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        convert(14'd1234, 16'h1234, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            convert(bvals[i], bexp[i], 1'b0, 1'b0);
            repeat (3) @(negedge Clk);
        end

        convert(14'd12000, 16'h9999, 1'b1, 1'b0);
        convert(14'd42, 16'h0042, 1'b0, 1'b0);

        convert(14'd5678, 16'h5678, 1'b0, 1'b1);
        expect_no_done(20);

        // Async reset mid-SHIFT discards the conversion in flight.
        Start  = 1'b1;
        Binary = 14'd8765;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        #1 Reset = 1'b0;
        #1;
        chk("async_rst_busy", Busy, 0);
        chk("async_rst_done", Done, 0);
        chk("async_rst_ovf", Overflow, 0);
        chk("async_rst_bcd", {BCD3, BCD2, BCD1, BCD0}, 0);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #2 Reset = 1'b1;
        expect_no_done(20);
        convert(14'd8765, 16'h8765, 1'b0, 1'b0);

        // Start held high: one conversion every 16 cycles.
        Start  = 1'b1;
        Binary = 14'd0;
        sb_q.push_back('{dec(0), 1'b0});
        for (int v = 0; v <= 20; v++) begin
            n = 0;
            do begin
                @(negedge Clk);
                n++;
            end while (!Done && n < 40);
            chk("b2b_interval", n, 16);
            if (v < 20) begin
                Binary = 14'(v + 1);
                sb_q.push_back('{dec(v + 1), 1'b0});
            end else begin
                Start = 1'b0;
            end
        end
        @(negedge Clk);
        chk("b2b_busy_end", Busy, 0);

        repeat (5) @(negedge Clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
